br_issue_sched: RTL and testbench
=================================

Name: br_issue_sched

Overview:
Branch reservation station and issue scheduler that shares the single branch ALU among in-flight branch/jump instructions. It holds up to NUM_ENT dispatched control-flow ops and wakes their source-A tag from the CDB. Each cycle it selects the oldest ready entry, ordered by ROB age relative to the ROB head, and drives the registered branch-ALU issue bundle. The block sits between dispatch and the branch FU; the PRF read of source A happens downstream using issue_pra_idx_o.

Parameters:
NUM_ENT, 4, number of branch RS entries (power of 2, at least 2)
ROB_IDX_W, 5, ROB index width (must equal `ROB_IDX_W)
PRF_IDX_W, 6, physical register tag width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
disp_en_i  in  1  dispatch a branch op this cycle
disp_npc_i  in  64  PC+4 of the branch
disp_inst_i  in  32  instruction word
disp_rob_idx_i  in  ROB_IDX_W  ROB slot of the branch
disp_pra_idx_i  in  PRF_IDX_W  physical tag of regA
disp_pra_rdy_i  in  1  regA already available
cdb_en_i  in  1  CDB broadcast valid
cdb_tag_i  in  PRF_IDX_W  CDB broadcast tag
rob_head_idx_i  in  ROB_IDX_W  current ROB head, used for age
squash_i  in  1  mispredict/exception flush from ROB
fu_stall_i  in  1  branch FU result cannot drain; hold issue
full_o  out  1  no free entry
count_o  out  log2(NUM_ENT)+1  number of valid entries
issue_start_o  out  1  start pulse to branch ALU
issue_npc_o  out  64  npc of the issued op
issue_inst_o  out  32  inst of the issued op
issue_rob_idx_o  out  ROB_IDX_W  rob index of the issued op
issue_pra_idx_o  out  PRF_IDX_W  regA tag for the PRF read

Behaviour:
- Reset: all entries invalid; full_o=0, count_o=0, issue_start_o=0. Issue data outputs reset to 0.
- Entry fields: valid, rdy, npc, inst, rob_idx, pra_idx.
- Dispatch:
  - When disp_en_i=1 and the block is not full, write the lowest-index free entry at the clock edge.
  - rdy = disp_pra_rdy_i OR (cdb_en_i AND cdb_tag_i==disp_pra_idx_i), which gives same-cycle CDB bypass.
  - disp_en_i while full_o=1 is a protocol violation; the write is ignored.
- full_o: combinational, equal to "all entries valid". It is conservative: an issue in the same cycle does not free a slot for that cycle's dispatch.
- Wakeup: any valid entry with rdy=0 and pra_idx==cdb_tag_i while cdb_en_i=1 sets rdy at the edge.
- Select (combinational):
  - Candidates are entries with valid & rdy, using the registered rdy. An entry woken this cycle issues no earlier than the next cycle.
  - age = (rob_idx - rob_head_idx_i) mod 2^ROB_IDX_W. Pick the minimum age; it is unique because ROB indices are unique.
  - Age must be correct across ROB wrap. Example: head=30, rob 31 has age 1 and rob 2 has age 4, so rob 31 wins.
- Issue:
  - If a candidate exists and fu_stall_i=0, then at the edge: issue_start_o<=1, the issue_* fields <= the selected entry's fields, and the entry is invalidated.
  - Otherwise issue_start_o<=0 and the issue_* data holds its previous values.
  - Minimum latency: an entry dispatched with rdy=1 at edge N is selected in cycle N to N+1 and drives issue_start_o=1 after edge N+1.
  - Throughput: one issue per cycle.
- Simultaneous events: dispatch into a free slot and issue from another slot in the same cycle are both performed. count_o = valid count after the edge.
- squash_i=1:
  - At the edge, all entries are invalidated and issue_start_o<=0.
  - Dispatch and issue in that cycle are suppressed; squash has highest priority after rst.
  - The cycle after a squash, full_o=0 and count_o=0.
- fu_stall_i=1: entries keep waking but none are removed. Squash still applies during a stall.

Decomposition:
- Shared package / sys_defs: ROB_IDX_W, PRF_IDX_W, and a br_rs_entry_t struct {valid, rdy, npc, inst, rob_idx, pra_idx}.
- Sub-module br_age_sel (combinational): inputs are the valid&rdy vector, rob_idx per entry and rob_head. Outputs are sel_valid and a one-hot sel. It is verified standalone.

Test Plan:
1. Reset, then dispatch rob=3 with pra_rdy=1, npc=0x104, inst=0xE4200004 -> issue_start_o=1 with npc 0x104 and rob 3 two edges after dispatch; count returns to 0.
2. Dispatch rob=5 (tag 12, not ready) then rob=6 (ready), head=0 -> rob 6 issues first. CDB tag 12 arrives in cycle k -> rob 5 issues with start high after edge k+1.
3. Wrap age: head=30, ready entries rob 2, 31, 30 -> issue order 30, 31, 2 on consecutive cycles.
4. Fill all 4 entries with none ready -> full_o=1 and count_o=4. A disp_en_i while full is dropped. CDB wakeup of one entry -> it issues, full_o drops to 0.
5. Same-cycle dispatch into a free slot with cdb_tag_i==disp_pra_idx_i -> entry marked ready, issues the next cycle.
6. Two ready entries, then squash_i together with disp_en_i -> next cycle count_o=0, issue_start_o=0, and no dispatched entry survives. fu_stall_i=1 for 3 cycles with ready entries -> issue_start_o=0 throughout, then oldest issues on release.

Source files
------------

// File: rtl/br_issue_sched_pkg.sv
// Shared definitions for the branch reservation station: index widths,
// default depth and the per-entry record held by the scheduler.
package br_issue_sched_pkg;

    localparam int SYS_ROB_IDX_W = 5;
    localparam int SYS_PRF_IDX_W = 6;
    localparam int SYS_BR_RS_ENT = 4;

    typedef struct packed {
        logic                     valid;
        logic                     rdy;
        logic [63:0]              npc;
        logic [31:0]              inst;
        logic [SYS_ROB_IDX_W-1:0] rob_idx;
        logic [SYS_PRF_IDX_W-1:0] pra_idx;
    } br_rs_entry_t;

endpackage

// File: rtl/br_issue_sched_if.sv
// Dispatch / CDB / ROB-control / issue bundle of the branch scheduler.
// The slave side is the scheduler itself; the master side drives it.
interface br_issue_sched_if
    import br_issue_sched_pkg::*;
#(
    parameter int NUM_ENT   = SYS_BR_RS_ENT,
    parameter int ROB_IDX_W = SYS_ROB_IDX_W,
    parameter int PRF_IDX_W = SYS_PRF_IDX_W
);
    localparam int CNT_W = $clog2(NUM_ENT) + 1;

    logic                 disp_en_i;
    logic [63:0]          disp_npc_i;
    logic [31:0]          disp_inst_i;
    logic [ROB_IDX_W-1:0] disp_rob_idx_i;
    logic [PRF_IDX_W-1:0] disp_pra_idx_i;
    logic                 disp_pra_rdy_i;
    logic                 cdb_en_i;
    logic [PRF_IDX_W-1:0] cdb_tag_i;
    logic [ROB_IDX_W-1:0] rob_head_idx_i;
    logic                 squash_i;
    logic                 fu_stall_i;
    logic                 full_o;
    logic [CNT_W-1:0]     count_o;
    logic                 issue_start_o;
    logic [63:0]          issue_npc_o;
    logic [31:0]          issue_inst_o;
    logic [ROB_IDX_W-1:0] issue_rob_idx_o;
    logic [PRF_IDX_W-1:0] issue_pra_idx_o;

    modport master (
        output disp_en_i, disp_npc_i, disp_inst_i, disp_rob_idx_i,
               disp_pra_idx_i, disp_pra_rdy_i, cdb_en_i, cdb_tag_i,
               rob_head_idx_i, squash_i, fu_stall_i,
        input  full_o, count_o, issue_start_o, issue_npc_o, issue_inst_o,
               issue_rob_idx_o, issue_pra_idx_o
    );

    modport slave (
        input  disp_en_i, disp_npc_i, disp_inst_i, disp_rob_idx_i,
               disp_pra_idx_i, disp_pra_rdy_i, cdb_en_i, cdb_tag_i,
               rob_head_idx_i, squash_i, fu_stall_i,
        output full_o, count_o, issue_start_o, issue_npc_o, issue_inst_o,
               issue_rob_idx_o, issue_pra_idx_o
    );

endinterface

// File: rtl/br_issue_sched_age_sel.sv
// Oldest-first picker: among requesting entries, choose the one whose ROB
// index is closest to the ROB head (distance taken modulo the ROB size so
// it stays correct across wrap). Result is one-hot.
module br_age_sel
    import br_issue_sched_pkg::*;
#(
    parameter int NUM_ENT   = SYS_BR_RS_ENT,
    parameter int ROB_IDX_W = SYS_ROB_IDX_W
) (
    input  logic [NUM_ENT-1:0]                req,
    input  logic [NUM_ENT-1:0][ROB_IDX_W-1:0] rob_idx,
    input  logic [ROB_IDX_W-1:0]              rob_head,
    output logic                              sel_valid,
    output logic [NUM_ENT-1:0]                sel
);

    logic [NUM_ENT-1:0][ROB_IDX_W-1:0] age;

    assign sel_valid = |req;

    generate
        for (genvar gi = 0; gi < NUM_ENT; gi++) begin : g_ent
            logic win;

            // Distance from head; the truncating subtraction is the modulo.
            assign age[gi] = rob_idx[gi] - rob_head;

            // An entry wins if no other requester is strictly older; equal
            // ages cannot occur with unique ROB slots, lower index breaks it anyway.
            always_comb begin
                win = req[gi];
                for (int j = 0; j < NUM_ENT; j++) begin
                    if (j != gi && req[j]) begin
                        if (age[j] < age[gi] || (age[j] == age[gi] && j < gi)) begin
                            win = 1'b0;
                        end
                    end
                end
            end

            assign sel[gi] = win;
        end
    endgenerate

endmodule

// File: rtl/br_issue_sched.sv
// Branch reservation station and issue scheduler. Holds dispatched
// control-flow ops, wakes their source-A tag from the CDB, and issues the
// oldest ready op (by ROB age) to the single branch ALU each cycle.
module br_issue_sched
    import br_issue_sched_pkg::*;
#(
    parameter int NUM_ENT   = SYS_BR_RS_ENT,
    parameter int ROB_IDX_W = SYS_ROB_IDX_W,
    parameter int PRF_IDX_W = SYS_PRF_IDX_W
) (
    input  logic            clk,
    input  logic            rst,
    br_issue_sched_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_ENT);
    localparam int CNT_W = IDX_W + 1;

    br_rs_entry_t entries_reg  [NUM_ENT];
    br_rs_entry_t entries_next [NUM_ENT];
    br_rs_entry_t new_ent;

    logic [NUM_ENT-1:0]                valid_vec;
    logic [NUM_ENT-1:0]                req_vec;
    logic [NUM_ENT-1:0][ROB_IDX_W-1:0] rob_vec;
    logic [NUM_ENT-1:0]                sel;
    logic                              sel_valid;

    logic             full;
    logic [IDX_W-1:0] free_idx;
    logic [CNT_W-1:0] count;
    logic             disp_fire;
    logic             issue_fire;
    logic             disp_rdy;

    logic [63:0]          sel_npc;
    logic [31:0]          sel_inst;
    logic [ROB_IDX_W-1:0] sel_rob;
    logic [PRF_IDX_W-1:0] sel_pra;

    logic                 issue_start_reg;
    logic [63:0]          issue_npc_reg;
    logic [31:0]          issue_inst_reg;
    logic [ROB_IDX_W-1:0] issue_rob_reg;
    logic [PRF_IDX_W-1:0] issue_pra_reg;

    generate
        for (genvar gi = 0; gi < NUM_ENT; gi++) begin : g_vec
            assign valid_vec[gi] = entries_reg[gi].valid;
            // Registered rdy only: a same-cycle wakeup issues next cycle.
            assign req_vec[gi]   = entries_reg[gi].valid & entries_reg[gi].rdy;
            assign rob_vec[gi]   = entries_reg[gi].rob_idx;
        end
    endgenerate

    br_age_sel #(
        .NUM_ENT   (NUM_ENT),
        .ROB_IDX_W (ROB_IDX_W)
    ) u_age_sel (
        .req       (req_vec),
        .rob_idx   (rob_vec),
        .rob_head  (bus.rob_head_idx_i),
        .sel_valid (sel_valid),
        .sel       (sel)
    );

    // Conservative full: a slot freed by this cycle's issue is not reused yet.
    assign full       = &valid_vec;
    assign disp_fire  = bus.disp_en_i && !full && !bus.squash_i;
    assign issue_fire = sel_valid && !bus.fu_stall_i && !bus.squash_i;
    assign disp_rdy   = bus.disp_pra_rdy_i ||
                        (bus.cdb_en_i && (bus.cdb_tag_i == bus.disp_pra_idx_i));

    // Lowest-index free slot for dispatch.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_ENT - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // Occupancy as seen after the last edge.
    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            count = count + CNT_W'(valid_vec[i]);
        end
    end

    // One-hot mux of the selected entry's payload.
    always_comb begin
        sel_npc  = '0;
        sel_inst = '0;
        sel_rob  = '0;
        sel_pra  = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (sel[i]) begin
                sel_npc  = sel_npc  | entries_reg[i].npc;
                sel_inst = sel_inst | entries_reg[i].inst;
                sel_rob  = sel_rob  | entries_reg[i].rob_idx;
                sel_pra  = sel_pra  | entries_reg[i].pra_idx;
            end
        end
    end

    // Next entry state: wakeup, issue removal, dispatch write, squash flush.
    always_comb begin
        new_ent.valid   = 1'b1;
        new_ent.rdy     = disp_rdy;
        new_ent.npc     = bus.disp_npc_i;
        new_ent.inst    = bus.disp_inst_i;
        new_ent.rob_idx = bus.disp_rob_idx_i;
        new_ent.pra_idx = bus.disp_pra_idx_i;
        for (int i = 0; i < NUM_ENT; i++) begin
            entries_next[i] = entries_reg[i];
            if (bus.cdb_en_i && entries_reg[i].valid && !entries_reg[i].rdy &&
                (entries_reg[i].pra_idx == bus.cdb_tag_i)) begin
                entries_next[i].rdy = 1'b1;
            end
            if (issue_fire && sel[i]) begin
                entries_next[i].valid = 1'b0;
            end
        end
        if (disp_fire) begin
            entries_next[free_idx] = new_ent;
        end
        if (bus.squash_i) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                entries_next[i].valid = 1'b0;
            end
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                entries_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENT; i++) begin
                entries_reg[i] <= entries_next[i];
            end
        end
    end

    // Registered issue bundle; payload holds when nothing issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_start_reg <= 1'b0;
            issue_npc_reg   <= '0;
            issue_inst_reg  <= '0;
            issue_rob_reg   <= '0;
            issue_pra_reg   <= '0;
        end else if (issue_fire) begin
            issue_start_reg <= 1'b1;
            issue_npc_reg   <= sel_npc;
            issue_inst_reg  <= sel_inst;
            issue_rob_reg   <= sel_rob;
            issue_pra_reg   <= sel_pra;
        end else begin
            issue_start_reg <= 1'b0;
        end
    end

    assign bus.full_o          = full;
    assign bus.count_o         = count;
    assign bus.issue_start_o   = issue_start_reg;
    assign bus.issue_npc_o     = issue_npc_reg;
    assign bus.issue_inst_o    = issue_inst_reg;
    assign bus.issue_rob_idx_o = issue_rob_reg;
    assign bus.issue_pra_idx_o = issue_pra_reg;

endmodule

// File: tb/tb_br_issue_sched.sv
// Scoreboard bench for br_issue_sched: a queue-based reference model
// predicts each issue; a negedge monitor compares what the DUT emits.
module tb_br_issue_sched;
    import br_issue_sched_pkg::*;

    localparam int NE = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    br_issue_sched_if #(.NUM_ENT(NE), .ROB_IDX_W(5), .PRF_IDX_W(6)) bif ();

    br_issue_sched #(.NUM_ENT(NE), .ROB_IDX_W(5), .PRF_IDX_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        logic [63:0] npc;
        logic [31:0] inst;
        logic [4:0]  rob;
        logic [5:0]  pra;
        bit          rdy;
    } ment_t;

    typedef struct {
        int          cyc;
        logic [63:0] npc;
        logic [31:0] inst;
        logic [4:0]  rob;
        logic [5:0]  pra;
    } exp_t;

    ment_t      mq[$];
    exp_t       eq[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [4:0] head = 5'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic int age_of(input logic [4:0] r);
        logic [4:0] d;
        d = r - head;
        return int'(d);
    endfunction

    // Drive one cycle of inputs, advance the model, then check occupancy.
    task automatic step(input bit en, input logic [4:0] rob, input logic [5:0] pra,
                        input bit prdy, input bit cen, input logic [5:0] ctag,
                        input bit sq, input bit stall,
                        input logic [63:0] npc, input logic [31:0] inst);
        int    best;
        bit    full_m;
        ment_t m;
        exp_t  e;
        bif.disp_en_i      = en;
        bif.disp_rob_idx_i = rob;
        bif.disp_pra_idx_i = pra;
        bif.disp_pra_rdy_i = prdy;
        bif.disp_npc_i     = npc;
        bif.disp_inst_i    = inst;
        bif.cdb_en_i       = cen;
        bif.cdb_tag_i      = ctag;
        bif.squash_i       = sq;
        bif.fu_stall_i     = stall;
        bif.rob_head_idx_i = head;
        full_m = (mq.size() == NE);
        if (sq) begin
            mq.delete();
        end else begin
            best = -1;
            foreach (mq[i]) begin
                if (mq[i].rdy && (best < 0 || age_of(mq[i].rob) < age_of(mq[best].rob)))
                    best = i;
            end
            if (best >= 0 && !stall) begin
                e.cyc  = cyc + 1;
                e.npc  = mq[best].npc;
                e.inst = mq[best].inst;
                e.rob  = mq[best].rob;
                e.pra  = mq[best].pra;
                eq.push_back(e);
                mq.delete(best);
            end
            foreach (mq[i]) begin
                if (cen && mq[i].pra == ctag) mq[i].rdy = 1'b1;
            end
            if (en && !full_m) begin
                m.npc  = npc;
                m.inst = inst;
                m.rob  = rob;
                m.pra  = pra;
                m.rdy  = prdy || (cen && ctag == pra);
                mq.push_back(m);
            end
        end
        @(posedge clk);
        #1;
        check("count", 64'(bif.count_o), 64'(mq.size()));
        check("full", 64'(bif.full_o), 64'(mq.size() == NE));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic stall_n(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    // Monitor: pop the scoreboard whenever the DUT starts an issue, and
    // flag any predicted issue whose cycle passed without a start pulse.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bif.issue_start_o) begin
                checks++;
                if (eq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_issue cyc=%0d got rob=%0d npc=%0h expected none",
                             cyc, bif.issue_rob_idx_o, bif.issue_npc_o);
                end else begin
                    e = eq.pop_front();
                    if (e.cyc != cyc || bif.issue_rob_idx_o !== e.rob || bif.issue_npc_o !== e.npc ||
                        bif.issue_inst_o !== e.inst || bif.issue_pra_idx_o !== e.pra) begin
                        errors++;
                        $display("FAIL issue cyc=%0d got rob=%0d npc=%0h inst=%0h pra=%0d expected cyc=%0d rob=%0d npc=%0h inst=%0h pra=%0d",
                                 cyc, bif.issue_rob_idx_o, bif.issue_npc_o, bif.issue_inst_o,
                                 bif.issue_pra_idx_o, e.cyc, e.rob, e.npc, e.inst, e.pra);
                    end else begin
                        $display("issue cyc=%0d rob=%0d npc=%0h inst=%0h pra=%0d",
                                 cyc, e.rob, e.npc, e.inst, e.pra);
                    end
                end
            end else if (eq.size() > 0 && eq[0].cyc <= cyc) begin
                checks++;
                errors++;
                e = eq.pop_front();
                $display("FAIL missing_issue cyc=%0d got start=0 expected rob=%0d",
                         cyc, e.rob);
            end
        end
    endtask

    initial begin
        logic [4:0] r;
        bit         used;
        rst = 1'b1;
        bif.disp_en_i = 0; bif.disp_npc_i = 0; bif.disp_inst_i = 0;
        bif.disp_rob_idx_i = 0; bif.disp_pra_idx_i = 0; bif.disp_pra_rdy_i = 0;
        bif.cdb_en_i = 0; bif.cdb_tag_i = 0; bif.rob_head_idx_i = 0;
        bif.squash_i = 0; bif.fu_stall_i = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", 64'(bif.count_o), 0);
        check("rst_full", 64'(bif.full_o), 0);
        check("rst_start", 64'(bif.issue_start_o), 0);
        check("rst_npc", bif.issue_npc_o, 0);
        check("rst_inst", 64'(bif.issue_inst_o), 0);
        check("rst_rob", 64'(bif.issue_rob_idx_o), 0);
        check("rst_pra", 64'(bif.issue_pra_idx_o), 0);
        rst = 1'b0;
        fork
            monitor();
        join_none

        // Minimum latency single op.
        head = 0;
        step(1, 3, 1, 1, 0, 0, 0, 0, 64'h104, 32'hE4200004);
        idle(3);
        // Younger ready op overtakes an unready older one; CDB then wakes it.
        step(1, 5, 12, 0, 0, 0, 0, 0, 64'h200, 32'h11);
        step(1, 6, 13, 1, 0, 0, 0, 0, 64'h204, 32'h12);
        idle(1);
        step(0, 0, 0, 0, 1, 12, 0, 0, 0, 0);
        idle(3);
        // Age across ROB wrap: expected order 30, 31, 2.
        head = 30;
        step(1, 2, 1, 1, 0, 0, 0, 1, 64'h300, 32'h21);
        step(1, 31, 1, 1, 0, 0, 0, 1, 64'h304, 32'h22);
        step(1, 30, 1, 1, 0, 0, 0, 1, 64'h308, 32'h23);
        idle(4);
        // Fill, drop a dispatch while full, wake one.
        head = 8;
        for (int k = 0; k < 4; k++)
            step(1, 5'(10 + k), 6'(20 + k), 0, 0, 0, 0, 0, 64'(64'h400 + 4 * k), 32'(k));
        step(1, 14, 24, 1, 0, 0, 0, 0, 64'h500, 32'h55);
        step(0, 0, 0, 0, 1, 21, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        // Same-cycle CDB bypass at dispatch.
        step(1, 7, 33, 0, 1, 33, 0, 0, 64'h600, 32'h66);
        idle(2);
        // Squash with a dispatch, then a 3-cycle stall and release.
        step(1, 1, 1, 1, 0, 0, 0, 1, 64'h700, 32'h71);
        step(1, 2, 1, 1, 0, 0, 0, 1, 64'h704, 32'h72);
        step(1, 3, 1, 1, 0, 0, 1, 0, 64'h708, 32'h73);
        idle(2);
        step(1, 4, 1, 1, 0, 0, 0, 1, 64'h800, 32'h81);
        step(1, 9, 1, 1, 0, 0, 0, 1, 64'h804, 32'h82);
        stall_n(3);
        idle(3);

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) == 0) head = 5'($urandom_range(0, 31));
            do begin
                r = 5'($urandom_range(0, 31));
                used = 0;
                foreach (mq[i]) if (mq[i].rob == r) used = 1;
            end while (used);
            step($urandom_range(0, 9) < 6, r, 6'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
                 6'($urandom_range(0, 7)), $urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) < 2, {$urandom, $urandom}, 32'($urandom));
        end
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(3);
        check("scoreboard_drained", 64'(eq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
